mod_engine_arbiter: RTL and testbench
=====================================

Name: mod_engine_arbiter

Overview:
- Shares one serial modulus/remainder engine between NREQ requesters.
- Each requester submits a W-bit word. The block grants requesters round-robin, feeds the word MSB-first into the remainder recurrence r = (2r + bit) mod MOD, and returns the remainder plus a divisible flag.
- It sits between parallel producers and the bit-serial divisibility datapath. Its job is sequencing and arbitration.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 8, data word width in bits (>=1); also the number of shift cycles per word.
- MOD, 3, modulus (>=2); remainder width RW = clog2(MOD).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous and active-low.
- req_valid  in  NREQ  per-requester word valid.
- req_data  in  NREQ*W  per-requester word; requester i uses bits [i*W +: W].
- req_ready  out  NREQ  one-hot grant/accept; combinational from state and arbitration.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accept.
- rsp_id  out  clog2(NREQ)  index of the requester that owns the result.
- rsp_rem  out  RW  final remainder.
- rsp_div  out  1  1 when rsp_rem == 0.

Behaviour:
- Reset (async assert, sync release): state IDLE, rr_ptr=0, remainder=0, bit counter=0. rsp_valid=0, rsp_id=0, rsp_rem=0, rsp_div=0, req_ready=0.
- States: IDLE, SHIFT, DONE.
- IDLE: if any req_valid is set, the winner g is the first set req_valid scanning rr_ptr, rr_ptr+1, ..., wrapping mod NREQ.
  - req_ready[g]=1 in that same cycle; all other req_ready bits are 0. req_ready is always 0 outside IDLE.
  - On the handshake edge t: capture req_data[g] and g, clear remainder to 0, load counter with W, set rr_ptr=(g+1) mod NREQ, go to SHIFT.
  - If no req_valid is set, stay in IDLE and leave rr_ptr unchanged.
- SHIFT: on each edge t+1..t+W, consume one bit MSB-first: r <= (2r + bit) mod MOD and decrement the counter.
  - Implement the modulo as a compare/subtract on a value below 2*MOD; no divider.
  - On edge t+W, go to DONE and register rsp_id, rsp_rem, rsp_div.
- DONE: rsp_valid=1 and all rsp_* outputs are held stable until rsp_valid & rsp_ready. On that edge go to IDLE with rsp_valid=0.
  - rsp_valid therefore first appears in the cycle after edge t+W.
- Throughput: at most one word per W+2 cycles, achieved when rsp_ready is held high.
- A word of all zeros yields rem=0, div=1.
- A requester dropping req_valid while not granted has no effect. Once a word is accepted it is processed to completion regardless of later req_valid or req_data activity.
- resetn asserted mid-SHIFT or mid-DONE aborts the operation immediately. No response is emitted for the aborted word.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,...

Optional Feature:
- Macro MODCHK_CHAIN_EN. When defined, a requester can split one arbitrarily long value across several words.
  - Added ports: req_last in NREQ (per-requester end-of-value flag) and rsp_last out 1 (echoes the captured req_last).
  - Added state: per-requester remainder store rem_q[NREQ], reset to 0.
  - On grant, the engine starts from rem_q[g] instead of 0.
  - At the SHIFT->DONE transition, rem_q[g] <= result if the captured last is 0, otherwise rem_q[g] <= 0.
  - A response is emitted for every word; rsp_rem is the partial remainder of the value so far.
  - Each requester's chain is independent, so interleaving chains from different requesters is legal.
- When undefined: req_last, rsp_last and rem_q do not exist, and every word is a standalone value starting from remainder 0.

Test Plan:
- MOD=3, W=8: requester 0 sends 0x0F -> rsp_id=0, rsp_rem=0, rsp_div=1, with rsp_valid first high in the cycle after edge t+8.
- Send 0x10 -> rem=1, div=0. Send 0xFF -> rem=0, div=1. Send 0x00 -> rem=0, div=1. Send 0x07 -> rem=1.
- All four requesters valid simultaneously with data 3,4,5,6 and rsp_ready=1: grant order 0,1,2,3; rem 0,1,2,0; one response every 10 cycles.
- Hold rsp_ready=0 for 5 cycles in DONE: rsp_* stays stable, req_ready stays 0, and no new grant occurs until the response handshake.
- Assert resetn=0 at the 4th shift cycle: all outputs read 0 immediately, no response is emitted, and rr_ptr reads 0 afterwards.
- With MODCHK_CHAIN_EN: requester 1 sends 0x01 (last=0) then 0x00 (last=1), giving the value 256 -> responses rem=1 then rem=1/div=0/rsp_last=1. A following 0x03 (last=1) from requester 1 -> rem=0, confirming rem_q was cleared.

Source files
------------

// File: rtl/mod_engine_arbiter.sv
// Round-robin arbiter feeding a shared bit-serial remainder engine (r = (2r + bit) mod MOD).
// Optional macro MODCHK_CHAIN_EN: per-requester partial remainders chain multi-word values.
module mod_engine_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int MOD  = 3,
    localparam int RW  = $clog2(MOD),
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
`ifdef MODCHK_CHAIN_EN
    input  logic [NREQ-1:0]     req_last,
    output logic                rsp_last,
`endif
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [RW-1:0]       rsp_rem,
    output logic                rsp_div,
    output logic [1:0]          dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits for ready, and valid plus payload stay stable until the transfer.

    localparam int CW = $clog2(W + 1);
    localparam logic [RW:0] MOD_W = (RW + 1)'(MOD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [RW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     data_q, data_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [RW-1:0]    rsp_rem_q, rsp_rem_d;
    logic             rsp_div_q, rsp_div_d;
`ifdef MODCHK_CHAIN_EN
    logic             last_q, last_d;
    logic             rsp_last_q, rsp_last_d;
    logic [RW-1:0]    rem_q [NREQ];
    logic [RW-1:0]    rem_d [NREQ];
`endif

    logic             gnt_found;
    logic [IDW-1:0]   gnt_id;
    int               scan_idx;
    logic [NREQ-1:0]  ready_c;
    logic [RW:0]      sum;
    logic [RW:0]      diff;
    logic [RW-1:0]    acc_next;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_idx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'(scan_idx);
            end
        end
    end

    // 2r + bit is below 2*MOD, so one conditional subtract reduces it.
    always_comb begin
        sum      = {acc_q, data_q[W-1]};
        diff     = sum - MOD_W;
        acc_next = (sum >= MOD_W) ? diff[RW-1:0] : sum[RW-1:0];
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        id_d      = id_q;
        rsp_id_d  = rsp_id_q;
        rsp_rem_d = rsp_rem_q;
        rsp_div_d = rsp_div_q;
        ready_c   = '0;
`ifdef MODCHK_CHAIN_EN
        last_d     = last_q;
        rsp_last_d = rsp_last_q;
        rem_d      = rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    ready_c[gnt_id] = 1'b1;
                    state_d  = SHIFT;
                    data_d   = req_data[int'(gnt_id)*W +: W];
                    id_d     = gnt_id;
                    cnt_d    = CW'(W);
                    rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
`ifdef MODCHK_CHAIN_EN
                    acc_d  = rem_q[gnt_id];
                    last_d = req_last[gnt_id];
`else
                    acc_d  = '0;
`endif
                end
            end
            SHIFT: begin
                acc_d  = acc_next;
                data_d = data_q << 1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d   = DONE;
                    rsp_id_d  = id_q;
                    rsp_rem_d = acc_next;
                    rsp_div_d = (acc_next == '0);
`ifdef MODCHK_CHAIN_EN
                    rsp_last_d  = last_q;
                    rem_d[id_q] = last_q ? '0 : acc_next;
`endif
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            id_q      <= '0;
            rsp_id_q  <= '0;
            rsp_rem_q <= '0;
            rsp_div_q <= 1'b0;
`ifdef MODCHK_CHAIN_EN
            last_q     <= 1'b0;
            rsp_last_q <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                rem_q[i] <= '0;
            end
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            id_q      <= id_d;
            rsp_id_q  <= rsp_id_d;
            rsp_rem_q <= rsp_rem_d;
            rsp_div_q <= rsp_div_d;
`ifdef MODCHK_CHAIN_EN
            last_q     <= last_d;
            rsp_last_q <= rsp_last_d;
            rem_q      <= rem_d;
`endif
        end
    end

    // Grants are masked while reset is held so nothing looks accepted during reset.
    assign req_ready = resetn ? ready_c : '0;
    assign rsp_valid = (state_q == DONE);
    assign rsp_id    = rsp_id_q;
    assign rsp_rem   = rsp_rem_q;
    assign rsp_div   = rsp_div_q;
    assign dbg_state = state_q;
`ifdef MODCHK_CHAIN_EN
    assign rsp_last  = rsp_last_q;
`endif

endmodule

// File: tb/tb_mod_engine_arbiter.sv
// Scoreboard bench for mod_engine_arbiter: directed words, arbitration order, backpressure, abort.
// Build with +define+MODCHK_CHAIN_EN to add the chained-value vectors.
module tb_mod_engine_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int MOD  = 3;
    localparam int RW   = $clog2(MOD);
    localparam int IDW  = $clog2(NREQ);
    localparam int EW   = IDW + RW + 2;
`ifdef MODCHK_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic              clk;
    logic              resetn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [RW-1:0]     rsp_rem;
    logic              rsp_div;
    logic [1:0]        dbg_state;
    logic              act_last;
`ifdef MODCHK_CHAIN_EN
    logic [NREQ-1:0]   req_last;
    logic              rsp_last;
`endif

    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];

    mod_engine_arbiter #(.NREQ(NREQ), .W(W), .MOD(MOD)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
`ifdef MODCHK_CHAIN_EN
        .req_last  (req_last),
        .rsp_last  (rsp_last),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_rem   (rsp_rem),
        .rsp_div   (rsp_div),
        .dbg_state (dbg_state)
    );

`ifdef MODCHK_CHAIN_EN
    assign act_last = rsp_last;
`else
    assign act_last = 1'b0;
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [EW-1:0] pack(input logic [IDW-1:0] id, input logic [RW-1:0] rem,
                                           input logic last);
        return {id, rem, (rem == '0), (CHAIN ? last : 1'b0)};
    endfunction

    // monitor / scoreboard
    logic [EW-1:0] exp_v;
    logic [EW-1:0] act_v;
    always @(negedge clk) begin
        if (resetn && rsp_valid && rsp_ready) begin
            checks++;
            act_v = {rsp_id, rsp_rem, rsp_div, act_last};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d rem=%0d div=%0d last=%0d, required none",
                         rsp_id, rsp_rem, rsp_div, act_last);
            end else begin
                exp_v = exp_q.pop_front();
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL rsp: got id=%0d rem=%0d div=%0d last=%0d, required id=%0d rem=%0d div=%0d last=%0d",
                             rsp_id, rsp_rem, rsp_div, act_last,
                             exp_v[EW-1 -: IDW], exp_v[RW+1:2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    // driver tasks
    task automatic issue(input int id, input logic [W-1:0] data, input logic [RW-1:0] rem,
                         input logic last, input bit expect_rsp);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        req_data[id*W +: W] = data;
        req_valid[id] = 1'b1;
`ifdef MODCHK_CHAIN_EN
        req_last[id] = last;
`endif
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout: requester %0d got no req_ready, required a grant", id);
        end else if (expect_rsp) begin
            exp_q.push_back(pack(IDW'(id), rem, last));
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    // Called just after the handshake edge t: rsp_valid must first rise in the cycle after edge t+W.
    task automatic check_latency();
        int k;
        bit seen;
        k = 1;
        seen = 1'b0;
        while (!seen && k < 3*W + 10) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
            else k++;
        end
        checks++;
        if (!seen || k != W + 1) begin
            errors++;
            $display("FAIL latency: rsp_valid first seen in cycle %0d (seen=%0d), required cycle %0d",
                     k, seen, W + 1);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || rsp_valid) && c < 200) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (c >= 200) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_rem !== '0 || rsp_div !== 1'b0 ||
            req_ready !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL %s: valid=%0d id=%0d rem=%0d div=%0d ready=%b state=%0d, required all 0",
                     name, rsp_valid, rsp_id, rsp_rem, rsp_div, req_ready, dbg_state);
        end
    endtask

    task automatic all_four();
        logic [W-1:0]    dtab [NREQ];
        logic [RW-1:0]   rtab [NREQ];
        logic [NREQ-1:0] exp_rdy;
        int n, last_cyc, cyc;
        dtab = '{8'd3, 8'd4, 8'd5, 8'd6};
        rtab = '{2'd0, 2'd1, 2'd2, 2'd0};
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = dtab[i];
`ifdef MODCHK_CHAIN_EN
        req_last = '1;
`endif
        req_valid = '1;
        n = 0;
        last_cyc = 0;
        cyc = 0;
        while (n < NREQ && cyc < 200) begin
            @(negedge clk);
            if (req_ready != '0) begin
                exp_rdy = '0;
                exp_rdy[n] = 1'b1;
                checks++;
                if (req_ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL grant_order: req_ready=%b, required %b", req_ready, exp_rdy);
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last_cyc != W + 2) begin
                        errors++;
                        $display("FAIL grant_spacing: %0d cycles between grants, required %0d",
                                 cyc - last_cyc, W + 2);
                    end
                end
                exp_q.push_back(pack(IDW'(n), rtab[n], 1'b1));
                last_cyc = cyc;
                @(posedge clk);
                #1;
                req_valid[n] = 1'b0;
                n++;
            end
            cyc++;
        end
        checks++;
        if (n != NREQ) begin
            errors++;
            $display("FAIL all_four_timeout: %0d grants seen, required %0d", n, NREQ);
        end
        req_valid = '0;
    endtask

    task automatic hold_test();
        int c;
        rsp_ready = 1'b0;
        issue(2, 8'h05, 2'd2, 1'b1, 1'b1);
        req_data[3*W +: W] = 8'h09;
`ifdef MODCHK_CHAIN_EN
        req_last[3] = 1'b1;
`endif
        req_valid[3] = 1'b1;
        c = 0;
        while (!rsp_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(2) || rsp_rem !== RW'(2) ||
                rsp_div !== 1'b0 || req_ready !== '0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: valid=%0d id=%0d rem=%0d div=%0d ready=%b, required 1/2/2/0/0000",
                         i, rsp_valid, rsp_id, rsp_rem, rsp_div, req_ready);
            end
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        issue(3, 8'h09, 2'd0, 1'b1, 1'b1);
        drain();
    endtask

    task automatic abort_test();
        issue(1, 8'hA5, 2'd0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b0;
        req_valid = '1;
        #1;
        check_all_zero("abort_outputs");
        repeat (3) @(posedge clk);
        #1;
        req_valid = '0;
        check_all_zero("abort_hold");
        @(negedge clk);
        resetn = 1'b1;
        repeat (2 * W) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_rsp: rsp_valid=%0d after abort, required 0", rsp_valid);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
`ifdef MODCHK_CHAIN_EN
        req_last  = '1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        @(negedge clk);
        resetn = 1'b1;

        issue(0, 8'h0F, 2'd0, 1'b1, 1'b1);
        check_latency();
        drain();
        issue(0, 8'h10, 2'd1, 1'b1, 1'b1);
        check_latency();
        drain();
        issue(0, 8'hFF, 2'd0, 1'b1, 1'b1);
        check_latency();
        drain();
        issue(0, 8'h00, 2'd0, 1'b1, 1'b1);
        check_latency();
        drain();
        issue(0, 8'h07, 2'd1, 1'b1, 1'b1);
        drain();

        hold_test();
        abort_test();
        all_four();
        drain();

`ifdef MODCHK_CHAIN_EN
        issue(1, 8'h01, 2'd1, 1'b0, 1'b1);
        drain();
        issue(1, 8'h00, 2'd1, 1'b1, 1'b1);
        drain();
        issue(1, 8'h03, 2'd0, 1'b1, 1'b1);
        drain();
`endif

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected responses never seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
